// File: rtl/bus_cmd_issue_pkg.sv
// Shared types for the host command issue stage: command ids, queued command
// record and FSM states.
package bus_cmd_issue_pkg;

    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = 2'b00;

    // Payload width carried by cmd_t; the top-level DATA_W must equal this.
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'd0,
        RW_WRITE = 2'd1,
        RW_READ  = 2'd2
    } rw_id_t;

    typedef struct packed {
        logic                  rw;
        logic [ADDR_W-1:0]     addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic {
        ST_ISSUE     = 1'b0,
        ST_WAIT_DONE = 1'b1
    } state_t;

    function automatic rw_id_t cmd_rw_id(input logic rw);
        return rw ? RW_WRITE : RW_READ;
    endfunction

endpackage

// File: rtl/bus_cmd_issue_fifo.sv
// Synchronous command FIFO (cmd_fifo): DEPTH entries of cmd_t, first-word
// fall-through head, pointers wrap modulo DEPTH.
module cmd_fifo
    import bus_cmd_issue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = CMD_DATA_W
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t push_cmd_i,
    input  logic pop_i,
    output cmd_t head_cmd_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic              mem_rw_q    [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q  [DEPTH];
    logic [DATA_W-1:0] mem_wdata_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        head_cmd_o       = '0;
        head_cmd_o.rw    = mem_rw_q[rd_ptr_q];
        head_cmd_o.addr  = mem_addr_q[rd_ptr_q];
        head_cmd_o.wdata = mem_wdata_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_rw_q[wr_ptr_q]    <= push_cmd_i.rw;
            mem_addr_q[wr_ptr_q]  <= push_cmd_i.addr;
            mem_wdata_q[wr_ptr_q] <= push_cmd_i.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bus_cmd_issue.sv
// Host command issue stage: buffers host requests and issues them on the
// Rd_Wr_Id/addres/wr_data bus, stalling after control writes until done.
// Optional statistics counters are enabled with BUS_CMD_ISSUE_STATS_EN.
//
// state        | meaning
// ST_ISSUE     | pop FIFO head (if any) and drive it onto the bus next cycle
// ST_WAIT_DONE | control write outstanding; wait for operation_done or timeout
module bus_cmd_issue
    import bus_cmd_issue_pkg::*;
#(
    parameter int DATA_W      = CMD_DATA_W,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_rw,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [1:0]        Rd_Wr_Id,
    output logic [ADDR_W-1:0] addres,
    output logic [DATA_W-1:0] wr_data,
    input  logic              operation_done,
    output logic              busy,
    output logic              timeout_err
`ifdef BUS_CMD_ISSUE_STATS_EN
    ,
    output logic [15:0]       issued_cnt,
    output logic [7:0]        timeout_cnt
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_t            state_q;
    rw_id_t            rw_id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              timeout_err_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    cmd_t push_cmd, head_cmd;
    logic fifo_full, fifo_empty, pop, timeout_hit;

    always_comb begin
        push_cmd       = '0;
        push_cmd.rw    = host_rw;
        push_cmd.addr  = host_addr;
        push_cmd.wdata = host_wdata;
    end

    assign pop         = (state_q == ST_ISSUE) && !fifo_empty;
    assign timeout_hit = (state_q == ST_WAIT_DONE) && !operation_done
                         && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (host_valid),
        .push_cmd_i (push_cmd),
        .pop_i      (pop),
        .head_cmd_o (head_cmd),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ISSUE;
            rw_id_q       <= RW_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            rw_id_q <= RW_IDLE;
            case (state_q)
                ST_ISSUE: begin
                    if (!fifo_empty) begin
                        rw_id_q <= cmd_rw_id(head_cmd.rw);
                        addr_q  <= head_cmd.addr;
                        // wr_data only follows writes; reads leave it holding
                        if (head_cmd.rw) wdata_q <= head_cmd.wdata;
                        if (head_cmd.rw && head_cmd.addr == CTRL_ADDR) begin
                            state_q    <= ST_WAIT_DONE;
                            wait_cnt_q <= '0;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (operation_done) begin
                        state_q    <= ST_ISSUE;
                        wait_cnt_q <= '0;
                    end else if (timeout_hit) begin
                        state_q       <= ST_ISSUE;
                        timeout_err_q <= 1'b1;
                        wait_cnt_q    <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_ISSUE;
            endcase
        end
    end

    assign host_ready  = !fifo_full;
    assign busy        = !fifo_empty || (state_q != ST_ISSUE);
    assign Rd_Wr_Id    = rw_id_q;
    assign addres      = addr_q;
    assign wr_data     = wdata_q;
    assign timeout_err = timeout_err_q;

`ifdef BUS_CMD_ISSUE_STATS_EN
    logic [15:0] issued_cnt_q;
    logic [7:0]  timeout_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            if (rw_id_q != RW_IDLE) issued_cnt_q <= issued_cnt_q + 1'b1;
            if (timeout_hit)        timeout_cnt_q <= timeout_cnt_q + 1'b1;
        end
    end

    assign issued_cnt  = issued_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
`endif

endmodule
